// File: rtl/aurora_packet_pkg.sv
// Shared types and field layout for the Aurora receive packet parser.
package aurora_packet_pkg;

   // Parser states: waiting for a header, collecting payload, or dropping a bad packet
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DISCARD = 2'd2
   } rxState_e;

   // Header beat layout: [31:16] magic, [15:8] source id, [7:0] payload length
   localparam int HDR_MAGIC_LSB = 16;
   localparam int HDR_SRC_LSB   = 8;
   localparam int HDR_LEN_LSB   = 0;

   // tuser flags carried on the tlast beat
   localparam int TUSER_CRC_PASS  = 0;
   localparam int TUSER_CRC_VALID = 1;

   localparam logic [15:0] DEFAULT_MAGIC = 16'hA5C3;
   localparam logic [3:0]  KEEP_ALL      = 4'hF;

endpackage

// File: rtl/aurora_packet_rx_buf.sv
// Payload staging RAM: one write port from the parser, one registered read port for the consumer.
module aurora_packet_rx_buf #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic          wrEn,
   input  logic [AW-1:0] wrAddr,
   input  logic [31:0]   wrData,
   input  logic [AW-1:0] rdAddr,
   output logic [31:0]   rdData
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdData_q;

   // Storage array has no reset; its contents only matter once a packet commits
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   // Registered read port, cleared by reset so the consumer sees zero after reset
   always_ff @(posedge clk) begin
      if (!resetN) begin
         rdData_q <= '0;
      end else begin
         rdData_q <= mem[rdAddr];
      end
   end

   assign rdData = rdData_q;

endmodule

// File: rtl/aurora_packet_rx.sv
// Receive-side packet parser: validates header, length, framing and CRC flags,
// stages payload and exposes only complete good packets, with per-cause counters.
module aurora_packet_rx
   import aurora_packet_pkg::*;
#(
   parameter  int          MAX_WORDS = 16,
   parameter  logic [15:0] MAGIC     = DEFAULT_MAGIC,
   parameter  int          CNT_WIDTH = 16,
   localparam int          AW        = $clog2(MAX_WORDS)
) (
   input  logic                 auUserClk,
   input  logic                 resetN,
   input  logic [31:0]          axiRxTdata,
   input  logic [3:0]           axiRxTkeep,
   input  logic [7:0]           axiRxTuser,
   input  logic                 axiRxTlast,
   input  logic                 axiRxTvalid,
   output logic                 pktValid,
   output logic [7:0]           pktSrc,
   output logic [7:0]           pktLen,
   input  logic                 pktAck,
   input  logic [AW-1:0]        rdAddr,
   output logic [31:0]          rdData,
   output logic [CNT_WIDTH-1:0] goodCount,
   output logic [CNT_WIDTH-1:0] hdrErrCount,
   output logic [CNT_WIDTH-1:0] lenErrCount,
   output logic [CNT_WIDTH-1:0] crcErrCount,
   output logic [CNT_WIDTH-1:0] overrunCount
);

   localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

   rxState_e state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic [7:0] len_q, len_d;
   logic [7:0] src_q, src_d;
   logic       pktValid_q;
   logic [7:0] pktSrc_q, pktLen_q;
   logic [CNT_WIDTH-1:0] good_q, hdrErr_q, lenErr_q, crcErr_q, overrun_q;

   logic        wrEn, commit, incHdr, incLen, incCrc, incOvr;
   logic [15:0] hdrMagic;
   logic [7:0]  hdrSrc, hdrLen;
   logic        keepOk, crcOk;
   logic [8:0]  cntInc;

   assign hdrMagic = axiRxTdata[HDR_MAGIC_LSB +: 16];
   assign hdrSrc   = axiRxTdata[HDR_SRC_LSB +: 8];
   assign hdrLen   = axiRxTdata[HDR_LEN_LSB +: 8];
   assign keepOk   = (axiRxTkeep == KEEP_ALL);
   assign cntInc   = cnt_q + 9'd1;
   // Reserved tuser bits are reduced into an always-true term so they are referenced without affecting the result
   assign crcOk    = axiRxTuser[TUSER_CRC_PASS] & axiRxTuser[TUSER_CRC_VALID] & (|{axiRxTuser[7:2], 1'b1});

   // Next-state decode: classify each beat and raise exactly one event per packet outcome
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      src_d   = src_q;
      wrEn    = 1'b0;
      commit  = 1'b0;
      incHdr  = 1'b0;
      incLen  = 1'b0;
      incCrc  = 1'b0;
      incOvr  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (axiRxTvalid) begin
               if (!keepOk || axiRxTlast || hdrLen == 8'd0 || {1'b0, hdrLen} > MAX_LEN) begin
                  incLen = 1'b1;
                  if (!axiRxTlast) state_d = DISCARD;
               end else if (hdrMagic != MAGIC) begin
                  incHdr  = 1'b1;
                  state_d = DISCARD;
               end else if (pktValid_q && !pktAck) begin
                  incOvr  = 1'b1;
                  state_d = DISCARD;
               end else begin
                  src_d   = hdrSrc;
                  len_d   = hdrLen;
                  cnt_d   = '0;
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (axiRxTvalid) begin
               if (!keepOk) begin
                  incLen  = 1'b1;
                  state_d = axiRxTlast ? IDLE : DISCARD;
               end else begin
                  wrEn  = 1'b1;
                  cnt_d = cntInc;
                  if (cntInc == {1'b0, len_q}) begin
                     if (!axiRxTlast) begin
                        incLen  = 1'b1;
                        state_d = DISCARD;
                     end else begin
                        if (crcOk) commit = 1'b1;
                        else       incCrc = 1'b1;
                        state_d = IDLE;
                     end
                  end else if (axiRxTlast) begin
                     incLen  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         DISCARD: begin
            if (axiRxTvalid && axiRxTlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Parser state and per-packet header latches
   always_ff @(posedge auUserClk) begin
      if (!resetN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         src_q   <= src_d;
      end
   end

   // Held-packet handshake: a commit publishes the packet, an ack while held releases it
   always_ff @(posedge auUserClk) begin
      if (!resetN) begin
         pktValid_q <= 1'b0;
         pktSrc_q   <= '0;
         pktLen_q   <= '0;
      end else if (commit) begin
         pktValid_q <= 1'b1;
         pktSrc_q   <= src_q;
         pktLen_q   <= len_q;
      end else if (pktAck && pktValid_q) begin
         pktValid_q <= 1'b0;
      end
   end

   // Saturating outcome counters for CSR readback
   always_ff @(posedge auUserClk) begin
      if (!resetN) begin
         good_q    <= '0;
         hdrErr_q  <= '0;
         lenErr_q  <= '0;
         crcErr_q  <= '0;
         overrun_q <= '0;
      end else begin
         if (commit && good_q    != '1) good_q    <= good_q    + 1'b1;
         if (incHdr && hdrErr_q  != '1) hdrErr_q  <= hdrErr_q  + 1'b1;
         if (incLen && lenErr_q  != '1) lenErr_q  <= lenErr_q  + 1'b1;
         if (incCrc && crcErr_q  != '1) crcErr_q  <= crcErr_q  + 1'b1;
         if (incOvr && overrun_q != '1) overrun_q <= overrun_q + 1'b1;
      end
   end

   aurora_packet_rx_buf #(.DEPTH(MAX_WORDS)) u_buf (
      .clk    (auUserClk),
      .resetN (resetN),
      .wrEn   (wrEn),
      .wrAddr (cnt_q[AW-1:0]),
      .wrData (axiRxTdata),
      .rdAddr (rdAddr),
      .rdData (rdData)
   );

   assign pktValid     = pktValid_q;
   assign pktSrc       = pktSrc_q;
   assign pktLen       = pktLen_q;
   assign goodCount    = good_q;
   assign hdrErrCount  = hdrErr_q;
   assign lenErrCount  = lenErr_q;
   assign crcErrCount  = crcErr_q;
   assign overrunCount = overrun_q;

endmodule
